// File: rtl/gpu_tile_sequencer_pkg.sv
// gpu_tile_sequencer_pkg: shared register map, sequencer states and camera types
package gpu_tile_sequencer_pkg;
   localparam int COORD_BITS = 8;
   localparam int FRAC_BITS  = 8;
   localparam int CAM_W      = COORD_BITS + FRAC_BITS;
   localparam int CAM_REGS   = 12;
   localparam logic [4:0] CONTROL        = 5'd0;
   localparam logic [4:0] STATUS         = 5'd1;
   localparam logic [4:0] PIXEL_BASE     = 5'd2;
   localparam logic [4:0] VOXEL_BUFFER   = 5'd3;
   localparam logic [4:0] VOXEL_COUNT    = 5'd4;
   localparam logic [4:0] PALETTE_BUFFER = 5'd5;
   localparam logic [4:0] PALETTE_LENGTH = 5'd6;
   localparam logic [4:0] CAM_BASE       = 5'd8;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, ADVANCE} seq_state_t;
   typedef struct packed {
      logic [CAM_W-1:0] x;
      logic [CAM_W-1:0] y;
      logic [CAM_W-1:0] z;
   } vec3_t;
   typedef struct packed {
      vec3_t look0;
      vec3_t look1;
      vec3_t look2;
      vec3_t look3;
   } camera_t;
endpackage

// File: rtl/gpu_tile_sequencer_csr.sv
// gpu_csr_regs: s1 decode, configuration storage frozen while busy, registered readback
module gpu_csr_regs
   import gpu_tile_sequencer_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  s1_address,
   input  logic        s1_read,
   input  logic        s1_write,
   input  logic [31:0] s1_writedata,
   output logic [31:0] s1_readdata,
   input  logic        busy_i,
   input  logic        done_i,
   input  logic [15:0] tiles_done_i,
   output logic        start_o,
   output logic        status_clr_o,
   output logic        ie_o,
   output logic [31:0] pixel_base_o,
   output logic [31:0] voxel_buffer_o,
   output logic [31:0] voxel_count_o,
   output logic [31:0] palette_buffer_o,
   output logic [31:0] palette_length_o,
   output camera_t     cam_o
);
   logic             ie_q;
   logic [31:0]      reg_q [2:6];
   logic [CAM_W-1:0] cam_q [CAM_REGS];
   logic [31:0]      rdata_q, rdata_d;
   logic [3:0]       cam_idx;
   logic             is_cfg, is_cam;
   assign cam_idx = 4'(s1_address - CAM_BASE);
   assign is_cfg  = s1_address >= PIXEL_BASE && s1_address <= PALETTE_LENGTH;
   assign is_cam  = s1_address >= CAM_BASE && s1_address < CAM_BASE + 5'd12;
   assign start_o      = s1_write && s1_address == CONTROL && s1_writedata[0];
   assign status_clr_o = s1_write && s1_address == STATUS && s1_writedata[0];
   assign ie_o             = ie_q;
   assign pixel_base_o     = reg_q[2];
   assign voxel_buffer_o   = reg_q[3];
   assign voxel_count_o    = reg_q[4];
   assign palette_buffer_o = reg_q[5];
   assign palette_length_o = reg_q[6];
   assign s1_readdata      = rdata_q;
   for (genvar g = 0; g < CAM_REGS; g++) begin : g_cam
      assign cam_o[(CAM_REGS-1-g)*CAM_W +: CAM_W] = cam_q[g];
   end
   // readback mux, unmapped addresses return zero
   always_comb begin
      rdata_d = (s1_address == CONTROL) ? {30'd0, ie_q, busy_i} :
                (s1_address == STATUS)  ? {tiles_done_i, 15'd0, done_i} :
                is_cfg                  ? reg_q[s1_address[2:0]] :
                is_cam                  ? 32'(cam_q[cam_idx]) : 32'd0;
   end
   // register storage; configuration only changes between frames, ie at any time
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ie_q    <= 1'b0;
         rdata_q <= '0;
         for (int i = 2; i <= 6; i++) reg_q[i] <= '0;
         for (int i = 0; i < CAM_REGS; i++) cam_q[i] <= '0;
      end else begin
         if (s1_write && s1_address == CONTROL) ie_q <= s1_writedata[1];
         if (s1_write && !busy_i && is_cfg) reg_q[s1_address[2:0]] <= s1_writedata;
         if (s1_write && !busy_i && is_cam) cam_q[cam_idx] <= s1_writedata[CAM_W-1:0];
         if (s1_read) rdata_q <= rdata_d;
      end
   end
endmodule

// File: rtl/gpu_tile_sequencer.sv
// gpu_tile_sequencer: walks the screen tile by tile, handshaking each tile with gpu_controller
module gpu_tile_sequencer
   import gpu_tile_sequencer_pkg::*;
#(
   parameter int MY_ROWS    = 8,
   parameter int MY_COLS    = 8,
   parameter int TOTAL_ROWS = 64,
   parameter int TOTAL_COLS = 64,
   parameter int PIXEL_BITS = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [4:0]            s1_address,
   input  logic                  s1_read,
   output logic [31:0]           s1_readdata,
   input  logic                  s1_write,
   input  logic [31:0]           s1_writedata,
   output logic                  irq,
   output camera_t               cam,
   output logic [PIXEL_BITS-1:0] start_row,
   output logic [PIXEL_BITS-1:0] start_col,
   output logic [31:0]           pixel_buffer,
   output logic [31:0]           voxel_buffer,
   output logic [31:0]           voxel_count,
   output logic [31:0]           palette_buffer,
   output logic [31:0]           palette_length,
   output logic                  do_render,
   output logic                  clear_interrupt,
   input  logic                  ctrl_irq
);
   localparam logic [PIXEL_BITS-1:0] LAST_ROW = PIXEL_BITS'(TOTAL_ROWS - MY_ROWS);
   localparam logic [PIXEL_BITS-1:0] LAST_COL = PIXEL_BITS'(TOTAL_COLS - MY_COLS);
   localparam logic [31:0]           TILE_PIX = 32'(MY_ROWS * MY_COLS);
   seq_state_t            state_q, state_d;
   logic [PIXEL_BITS-1:0] row_q, row_d, col_q, col_d;
   logic [31:0]           off_q, off_d, pixel_base;
   logic [15:0]           tiles_q, tiles_d;
   logic                  done_q, done_d, busy, start, status_clr, ie;
   assign busy            = state_q != IDLE;
   assign start_row       = row_q;
   assign start_col       = col_q;
   assign pixel_buffer    = pixel_base + off_q;
   assign do_render       = state_q == ISSUE;
   assign clear_interrupt = state_q == ACK;
   assign irq             = done_q & ie;
   gpu_csr_regs u_csr (
      .clock            (clock),
      .reset            (reset),
      .s1_address       (s1_address),
      .s1_read          (s1_read),
      .s1_write         (s1_write),
      .s1_writedata     (s1_writedata),
      .s1_readdata      (s1_readdata),
      .busy_i           (busy),
      .done_i           (done_q),
      .tiles_done_i     (tiles_q),
      .start_o          (start),
      .status_clr_o     (status_clr),
      .ie_o             (ie),
      .pixel_base_o     (pixel_base),
      .voxel_buffer_o   (voxel_buffer),
      .voxel_count_o    (voxel_count),
      .palette_buffer_o (palette_buffer),
      .palette_length_o (palette_length),
      .cam_o            (cam)
   );
   // next-state: tile walk and controller handshake; a done set beats a same-cycle clear
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      off_d   = off_q;
      tiles_d = tiles_q;
      done_d  = status_clr ? 1'b0 : done_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = ISSUE;
            row_d   = '0;
            col_d   = '0;
            off_d   = '0;
            tiles_d = '0;
            done_d  = 1'b0;
         end
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = ctrl_irq ? ACK : WAIT;
         ACK:     state_d = ctrl_irq ? ACK : ADVANCE;
         ADVANCE: begin
            tiles_d = tiles_q + 16'd1;
            off_d   = off_q + TILE_PIX;
            state_d = ISSUE;
            if (row_q == LAST_ROW && col_q == LAST_COL) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (col_q == LAST_COL) begin
               col_d = '0;
               row_d = row_q + PIXEL_BITS'(MY_ROWS);
            end else begin
               col_d = col_q + PIXEL_BITS'(MY_COLS);
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // sequencer state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         off_q   <= '0;
         tiles_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         off_q   <= off_d;
         tiles_q <= tiles_d;
         done_q  <= done_d;
      end
   end
endmodule
